// File: rtl/alu_cmd_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_cmd_driver
// Brief    : Valid/ready command front-end for one combinational ALU. Keeps a
//            running accumulator, drives the ALU from registered opcode and
//            operand, writes the ALU result back, and returns every result on
//            a valid/ready response channel.
// Options  : define ALU_CMD_DRIVER_STATUS_EN to add rsp_zero_o / rsp_divz_o.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_driver #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // command channel
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_load_i,
    input  logic [2:0]            cmd_oc_i,
    input  logic [DATA_WIDTH-1:0] cmd_data_i,
    // ALU side
    output logic [2:0]            alu_oc_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    input  logic [DATA_WIDTH-1:0] alu_f_i,
    // response channel
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic [DATA_WIDTH-1:0] acc_o
`ifdef ALU_CMD_DRIVER_STATUS_EN
    ,
    output logic                  rsp_zero_o,
    output logic                  rsp_divz_o
`endif
);

    localparam logic [2:0] C_OC_DIV = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                  state_q,     state_d;
    logic [DATA_WIDTH-1:0]   acc_q,       acc_d;
    logic [2:0]              alu_oc_q,    alu_oc_d;
    logic [DATA_WIDTH-1:0]   alu_b_q,     alu_b_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q,  rsp_data_d;
    logic                    rsp_valid_q, rsp_valid_d;

    // Command acceptance is a pure state decode so it never loops back on cmd_valid.
    assign cmd_ready_o = (state_q == S_IDLE);
    assign alu_oc_o    = alu_oc_q;
    assign alu_a_o     = acc_q;
    assign alu_b_o     = alu_b_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign acc_o       = acc_q;

    // Next-state and datapath update; every register holds unless a state acts on it.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        alu_oc_d    = alu_oc_q;
        alu_b_d     = alu_b_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_load_i) begin
                        // Loads bypass the ALU and leave its input registers untouched.
                        acc_d       = cmd_data_i;
                        rsp_data_d  = cmd_data_i;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        alu_oc_d = cmd_oc_i;
                        alu_b_d  = cmd_data_i;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // ALU inputs were registered last edge; its result is settled now.
                acc_d       = alu_f_i;
                rsp_data_d  = alu_f_i;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight command at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            alu_oc_q    <= '0;
            alu_b_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            alu_oc_q    <= alu_oc_d;
            alu_b_q     <= alu_b_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef ALU_CMD_DRIVER_STATUS_EN
    logic rsp_zero_q, rsp_zero_d;
    logic rsp_divz_q, rsp_divz_d;

    assign rsp_zero_o = rsp_zero_q;
    assign rsp_divz_o = rsp_divz_q;

    // Status flags are updated on exactly the edges that load rsp_data.
    always_comb begin
        rsp_zero_d = rsp_zero_q;
        rsp_divz_d = rsp_divz_q;
        if ((state_q == S_IDLE) && cmd_valid_i && cmd_load_i) begin
            rsp_zero_d = (cmd_data_i == '0);
            rsp_divz_d = 1'b0;
        end else if (state_q == S_ISSUE) begin
            rsp_zero_d = (alu_f_i == '0);
            rsp_divz_d = (alu_oc_q == C_OC_DIV) && (alu_b_q == '0);
        end
    end

    // Status flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_zero_q <= 1'b0;
            rsp_divz_q <= 1'b0;
        end else begin
            rsp_zero_q <= rsp_zero_d;
            rsp_divz_q <= rsp_divz_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_driver
// Brief    : Self-checking bench for alu_cmd_driver. Supplies a behavioural
//            ALU, drives directed and random commands, and compares against an
//            accumulator model built from modular arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_driver;

    localparam int    DW  = 16;
    localparam longint MOD = longint'(1) << DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_load;
    logic [2:0]    cmd_oc;
    logic [DW-1:0] cmd_data;
    logic [2:0]    alu_oc;
    logic [DW-1:0] alu_a, alu_b, alu_f;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data, acc;
`ifdef ALU_CMD_DRIVER_STATUS_EN
    logic          rsp_zero, rsp_divz;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // model state
    longint        acc_m    = 0;
    logic [2:0]    alu_oc_m = '0;
    logic [DW-1:0] alu_b_m  = '0;

    alu_cmd_driver #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_load_i  (cmd_load),
        .cmd_oc_i    (cmd_oc),
        .cmd_data_i  (cmd_data),
        .alu_oc_o    (alu_oc),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_f_i     (alu_f),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .acc_o       (acc)
`ifdef ALU_CMD_DRIVER_STATUS_EN
        ,
        .rsp_zero_o  (rsp_zero),
        .rsp_divz_o  (rsp_divz)
`endif
    );

    always #5 clk = ~clk;

    // Combinational ALU the driver sits in front of.
    always_comb begin
        case (alu_oc)
            3'd0:    alu_f = alu_a + alu_b;
            3'd1:    alu_f = alu_a - alu_b;
            3'd2:    alu_f = alu_a * alu_b;
            3'd3:    alu_f = (alu_b == '0) ? '0 : alu_a / alu_b;
            3'd4:    alu_f = ~alu_a;
            3'd5:    alu_f = alu_a ^ alu_b;
            3'd6:    alu_f = alu_a | alu_b;
            default: alu_f = alu_a & alu_b;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference result from modular integer arithmetic.
    function automatic longint ref_alu(input int oc, input longint a, input longint b);
        case (oc)
            0:       return (a + b) % MOD;
            1:       return (a - b + MOD) % MOD;
            2:       return (a * b) % MOD;
            3:       return (b == 0) ? 0 : a / b;
            4:       return MOD - 1 - a;
            5:       return a ^ b;
            6:       return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic check_held(input string tag, input longint exp);
        chk({tag, "_vld"},  rsp_valid, 1);
        chk({tag, "_data"}, rsp_data, exp[31:0]);
        chk({tag, "_acc"},  acc, exp[31:0]);
        chk({tag, "_rdy"},  cmd_ready, 0);
        chk({tag, "_aoc"},  alu_oc, alu_oc_m);
        chk({tag, "_ab"},   alu_b, alu_b_m);
    endtask

    // One command, entered and left on a falling edge with the DUT idle.
    task automatic run_cmd(input bit ld, input logic [2:0] oc, input logic [DW-1:0] d,
                           input int bp);
        longint exp;
        bit     divz_e;
        exp    = ld ? longint'(d) : ref_alu(int'(oc), acc_m, longint'(d));
        divz_e = !ld && (oc == 3'd3) && (d == '0);
        chk("idle_rdy", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_oc    = oc;
        cmd_data  = d;
        rsp_ready = 1'($urandom_range(0, 1));
        @(negedge clk);                      // accept edge E0 has passed
        cmd_valid = 1'b0;
        cmd_data  = DW'($urandom);
        cmd_oc    = 3'($urandom);
        if (!ld) begin
            chk("issue_vld", rsp_valid, 0);
            chk("issue_oc",  alu_oc, oc);
            chk("issue_b",   alu_b, d);
            chk("issue_a",   alu_a, acc_m[31:0]);
            chk("issue_rdy", cmd_ready, 0);
            @(negedge clk);                  // E0+1 has passed
            alu_oc_m = oc;
            alu_b_m  = d;
        end
        acc_m = exp;
        check_held("rsp", exp);
`ifdef ALU_CMD_DRIVER_STATUS_EN
        chk("rsp_zero", rsp_zero, (exp == 0));
        chk("rsp_divz", rsp_divz, divz_e);
`endif
        for (int i = 0; i < bp; i++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;                // must be ignored outside IDLE
            cmd_load  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_held("bp", exp);
`ifdef ALU_CMD_DRIVER_STATUS_EN
            chk("bp_zero", rsp_zero, (exp == 0));
            chk("bp_divz", rsp_divz, divz_e);
`endif
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("done_vld", rsp_valid, 0);
        chk("done_rdy", cmd_ready, 1);
        chk("done_acc", acc, acc_m[31:0]);
        rsp_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_load  = 1'b1;
        cmd_oc    = 3'd0;
        cmd_data  = 16'hABCD;
        rsp_ready = 1'b0;

        // Reset held with a command pending
        repeat (3) @(negedge clk);
        chk("rst_vld",  rsp_valid, 0);
        chk("rst_acc",  acc, 0);
        chk("rst_oc",   alu_oc, 0);
        chk("rst_b",    alu_b, 0);
        chk("rst_data", rsp_data, 0);
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", cmd_ready, 1);
        chk("post_rst_vld", rsp_valid, 0);

        // Directed sequences
        run_cmd(1'b1, 3'd0, 16'h0005, 0);
        run_cmd(1'b0, 3'd0, 16'h0003, 0);
        chk("add_acc", acc, 16'h0008);
        run_cmd(1'b1, 3'd0, 16'h0002, 0);
        run_cmd(1'b0, 3'd1, 16'h0005, 0);
        chk("sub_acc", acc, 16'hFFFD);
        run_cmd(1'b1, 3'd0, 16'h0100, 0);
        run_cmd(1'b0, 3'd2, 16'h0100, 0);
        chk("mul_acc", acc, 16'h0000);
        run_cmd(1'b1, 3'd0, 16'h0010, 0);
        run_cmd(1'b0, 3'd3, 16'h0000, 0);
        chk("divz_acc", acc, 16'h0000);
        run_cmd(1'b1, 3'd0, 16'h0010, 0);
        run_cmd(1'b0, 3'd3, 16'h0004, 5);    // with backpressure
        chk("div_acc", acc, 16'h0004);
        run_cmd(1'b1, 3'd7, 16'h1234, 5);    // load with backpressure, opcode ignored

        // Randomised commands
        for (int n = 0; n < 80; n++) begin
            bit            ld;
            logic [DW-1:0] d;
            ld = ($urandom_range(0, 3) == 0);
            d  = ($urandom_range(0, 5) == 0) ? '0 : DW'($urandom);
            run_cmd(ld, 3'($urandom), d, int'($urandom_range(0, 3)));
        end

        // Reset asserted during the ISSUE cycle
        run_cmd(1'b1, 3'd0, 16'h1234, 0);
        cmd_valid = 1'b1;
        cmd_load  = 1'b0;
        cmd_oc    = 3'd0;
        cmd_data  = 16'h0001;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_issue_vld", rsp_valid, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_acc",  acc, 0);
        chk("mid_rst_vld",  rsp_valid, 0);
        chk("mid_rst_data", rsp_data, 0);
        chk("mid_rst_b",    alu_b, 0);
`ifdef ALU_CMD_DRIVER_STATUS_EN
        chk("mid_rst_zero", rsp_zero, 0);
`endif
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b0;
        acc_m     = 0;
        alu_oc_m  = '0;
        alu_b_m   = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_mid_vld", rsp_valid, 0);
            chk("post_mid_rdy", cmd_ready, 1);
        end
        run_cmd(1'b0, 3'd0, 16'h0007, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
